// File: rtl/inst_envelope.sv
// Per-instrument visual envelope: triggers are collected during the frame and
// folded into the levels by a once-per-frame decay/peak sweep across instruments.

module inst_envelope_lane #(
  parameter int DECAY_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit_i,    // accepted trigger for this instrument
  input  logic [7:0] peak_i,
  input  logic       proc_i,   // sweep is on this instrument this cycle
  output logic [7:0] level_o
);
  logic       pend_q, pend_d;
  logic [7:0] peak_q, peak_d;
  logic [7:0] level_q, level_d;
  logic [7:0] shifted, step, decayed;

  always_comb begin
    shifted = level_q >> DECAY_SHIFT;
    step    = (shifted == 8'd0) ? 8'd1 : shifted;
    decayed = (level_q <= 8'd1) ? 8'd0 : level_q - step;
  end

  // A trigger landing in the cycle this instrument is swept starts a fresh
  // pending entry for next frame; the sweep itself uses the old entry.
  always_comb begin
    pend_d  = pend_q;
    peak_d  = peak_q;
    level_d = level_q;
    if (proc_i) begin
      level_d = (pend_q && peak_q > decayed) ? peak_q : decayed;
      pend_d  = 1'b0;
      peak_d  = 8'd0;
    end
    if (hit_i) begin
      pend_d = 1'b1;
      if (pend_q && !proc_i && peak_q > peak_i) peak_d = peak_q;
      else                                      peak_d = peak_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      peak_q  <= 8'd0;
      level_q <= 8'd0;
    end else begin
      pend_q  <= pend_d;
      peak_q  <= peak_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
endmodule

module inst_envelope #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int DECAY_SHIFT      = 3,
  parameter int IDX_W            = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_frame,
  input  logic             trig_valid,
  input  logic [IDX_W-1:0] trig_inst,
  input  logic [6:0]       trig_velocity,
  output logic [7:0]       inst_intensity [INSTRUMENT_COUNT-1:0],
  output logic             busy
);
  typedef enum logic {IDLE, UPDATE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTRUMENT_COUNT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             trig_acc;
  logic [7:0]       peak;

  assign trig_acc = trig_valid && (trig_velocity != 7'd0) &&
                    (32'(trig_inst) < 32'(INSTRUMENT_COUNT));
  assign peak     = {trig_velocity, trig_velocity[6]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (new_frame) begin
        state_d = UPDATE;
        idx_d   = '0;
      end
      UPDATE: begin
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == UPDATE);
  end

  for (genvar g = 0; g < INSTRUMENT_COUNT; g++) begin : g_lane
    inst_envelope_lane #(.DECAY_SHIFT(DECAY_SHIFT)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .hit_i   (trig_acc && trig_inst == IDX_W'(g)),
      .peak_i  (peak),
      .proc_i  (busy && idx_q == IDX_W'(g)),
      .level_o (inst_intensity[g])
    );
  end
endmodule
